// File: rtl/leaky_relu_derivative_child.sv
// Leaky ReLU derivative column unit: records forward activation signs in a FIFO and
// applies the derivative to the backward gradient stream. Optional macro: LRD_BYPASS_EN.

module fxp_mul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic signed [31:0] prod;

  // Q8.8 x Q8.8 -> Q16.16, truncated back to Q8.8
  assign prod = $signed(32'(signed'(a))) * $signed(32'(signed'(b)));
  assign y    = 16'(prod >>> 8);
endmodule

module leaky_relu_derivative_child #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lrd_clear_in,
  input  logic                       lrd_h_valid_in,
  input  logic [15:0]                lrd_h_data_in,
  input  logic                       lrd_valid_in,
  input  logic [15:0]                lrd_data_in,
  input  logic [15:0]                lrd_leak_factor_in,
  output logic [15:0]                lrd_data_out,
  output logic                       lrd_valid_out,
  output logic [$clog2(DEPTH):0]     lrd_count_out,
  output logic                       lrd_full_out,
  output logic                       lrd_overflow_out,
  output logic                       lrd_underflow_out
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 16;

  logic          mask_q [DEPTH];
  logic          mask_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;

  logic          h_neg;
  logic          empty;
  logic          full;
  logic          bypass;
  logic          pop_ok;
  logic          push_store;
  logic          sel_neg;
  logic [DW-1:0] mul_y;

  fxp_mul u_fxp_mul (
    .a (lrd_data_in),
    .b (lrd_leak_factor_in),
    .y (mul_y)
  );

  // Zero counts as non-negative, so only the sign bit matters
  assign h_neg = $signed(lrd_h_data_in) < 16'sd0;
  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));

`ifdef LRD_BYPASS_EN
  assign bypass = empty & lrd_h_valid_in & lrd_valid_in;
`else
  assign bypass = 1'b0;
`endif

  assign pop_ok     = lrd_valid_in & ~empty;
  assign push_store = lrd_h_valid_in & (~full | pop_ok) & ~bypass;
  assign sel_neg    = bypass ? h_neg : mask_q[rd_ptr_q];

  always_comb begin
    mask_d   = mask_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    data_d   = '0;
    valid_d  = 1'b0;

    if (lrd_clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push_store) begin
        mask_d[wr_ptr_q] = h_neg;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (lrd_h_valid_in && full && !lrd_valid_in) begin
        ovf_d = 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // Gradient path: scale on a recorded negative, otherwise pass through
      if (lrd_valid_in) begin
        valid_d = 1'b1;
        if ((pop_ok || bypass) && sel_neg) begin
          data_d = mul_y;
        end else begin
          data_d = lrd_data_in;
        end
        if (!pop_ok && !bypass) begin
          unf_d = 1'b1;
        end
      end
      if (push_store && !pop_ok) begin
        count_d = count_q + CW'(1);
      end else if (pop_ok && !push_store) begin
        count_d = count_q - CW'(1);
      end
    end
    full_d = (count_d == CW'(DEPTH));
  end

  // Mask contents are don't-care after reset; only pointers and count are reset
  always_ff @(posedge clk) begin
    mask_q <= mask_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign lrd_data_out      = data_q;
  assign lrd_valid_out     = valid_q;
  assign lrd_count_out     = count_q;
  assign lrd_full_out      = full_q;
  assign lrd_overflow_out  = ovf_q;
  assign lrd_underflow_out = unf_q;

endmodule

// File: tb/tb_leaky_relu_derivative_child.sv
// Directed self-checking bench for leaky_relu_derivative_child.
module tb_leaky_relu_derivative_child;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lrd_clear_in;
  logic          lrd_h_valid_in;
  logic [15:0]   lrd_h_data_in;
  logic          lrd_valid_in;
  logic [15:0]   lrd_data_in;
  logic [15:0]   lrd_leak_factor_in;
  logic [15:0]   lrd_data_out;
  logic          lrd_valid_out;
  logic [CW-1:0] lrd_count_out;
  logic          lrd_full_out;
  logic          lrd_overflow_out;
  logic          lrd_underflow_out;

  int checks   = 0;
  int failures = 0;

  leaky_relu_derivative_child #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lrd_clear_in       (lrd_clear_in),
    .lrd_h_valid_in     (lrd_h_valid_in),
    .lrd_h_data_in      (lrd_h_data_in),
    .lrd_valid_in       (lrd_valid_in),
    .lrd_data_in        (lrd_data_in),
    .lrd_leak_factor_in (lrd_leak_factor_in),
    .lrd_data_out       (lrd_data_out),
    .lrd_valid_out      (lrd_valid_out),
    .lrd_count_out      (lrd_count_out),
    .lrd_full_out       (lrd_full_out),
    .lrd_overflow_out   (lrd_overflow_out),
    .lrd_underflow_out  (lrd_underflow_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    lrd_clear_in   = 1'b0;
    lrd_h_valid_in = 1'b0;
    lrd_h_data_in  = 16'h0000;
    lrd_valid_in   = 1'b0;
    lrd_data_in    = 16'h0000;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(lrd_data_out), 32'h0);
    chk({tag, "_valid"}, 32'(lrd_valid_out), 32'h0);
    chk({tag, "_count"}, 32'(lrd_count_out), 32'h0);
    chk({tag, "_full"},  32'(lrd_full_out), 32'h0);
    chk({tag, "_ovf"},   32'(lrd_overflow_out), 32'h0);
    chk({tag, "_unf"},   32'(lrd_underflow_out), 32'h0);
  endtask

  initial begin
    logic [15:0] exp_d;
    rst_n = 1'b0;
    idle_inputs();
    lrd_leak_factor_in = 16'h0020;
    #3;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic: +1.0, -1.0, 0 then three gradients of 2.0
    lrd_h_valid_in = 1'b1;
    lrd_h_data_in = 16'h0100; tick();
    lrd_h_data_in = 16'hFF00; tick();
    lrd_h_data_in = 16'h0000; tick();
    lrd_h_valid_in = 1'b0;
    chk("basic_count3", 32'(lrd_count_out), 32'd3);
    lrd_valid_in = 1'b1;
    lrd_data_in  = 16'h0200;
    tick();
    chk("basic_out0", 32'(lrd_data_out), 32'h0200);
    chk("basic_v0", 32'(lrd_valid_out), 32'h1);
    tick();
    chk("basic_out1", 32'(lrd_data_out), 32'h0040);
    tick();
    chk("basic_out2", 32'(lrd_data_out), 32'h0200);
    chk("basic_count0", 32'(lrd_count_out), 32'd0);
    idle_inputs();
    tick();
    chk("idle_valid", 32'(lrd_valid_out), 32'h0);
    chk("idle_data", 32'(lrd_data_out), 32'h0);
    chk("basic_unf", 32'(lrd_underflow_out), 32'h0);

    // Fill with negatives, then overflow
    lrd_h_valid_in = 1'b1;
    lrd_h_data_in  = 16'hFF00;
    for (int i = 0; i < int'(DEPTH); i++) tick();
    chk("fill_count", 32'(lrd_count_out), 32'(DEPTH));
    chk("fill_full", 32'(lrd_full_out), 32'h1);
    chk("fill_ovf0", 32'(lrd_overflow_out), 32'h0);
    tick();
    lrd_h_valid_in = 1'b0;
    chk("ovf_flag", 32'(lrd_overflow_out), 32'h1);
    chk("ovf_count", 32'(lrd_count_out), 32'(DEPTH));
    lrd_valid_in = 1'b1;
    lrd_data_in  = 16'hFE00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      tick();
      chk($sformatf("drain_%0d", i), 32'(lrd_data_out), 32'hFFC0);
    end
    lrd_valid_in = 1'b0;
    chk("drain_count", 32'(lrd_count_out), 32'd0);
    chk("drain_full", 32'(lrd_full_out), 32'h0);
    chk("drain_unf", 32'(lrd_underflow_out), 32'h0);

    // Clear, then full FIFO with simultaneous push/pop across the wrap
    lrd_clear_in = 1'b1; tick(); lrd_clear_in = 1'b0;
    chk("clr_ovf", 32'(lrd_overflow_out), 32'h0);
    lrd_h_valid_in = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      lrd_h_data_in = (i % 2 == 1) ? 16'h8000 : 16'h7FFF;
      tick();
    end
    chk("wrap_fill", 32'(lrd_count_out), 32'(DEPTH));
    lrd_valid_in = 1'b1;
    lrd_data_in  = 16'h0200;
    for (int i = 0; i < int'(DEPTH); i++) begin
      lrd_h_data_in = (i % 3 == 0) ? 16'hFF00 : 16'h0100;
      tick();
      exp_d = (i % 2 == 1) ? 16'h0040 : 16'h0200;
      chk($sformatf("wrap_pp_%0d", i), 32'(lrd_data_out), 32'(exp_d));
      chk($sformatf("wrap_cnt_%0d", i), 32'(lrd_count_out), 32'(DEPTH));
    end
    lrd_h_valid_in = 1'b0;
    chk("wrap_noovf", 32'(lrd_overflow_out), 32'h0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      tick();
      exp_d = (i % 3 == 0) ? 16'h0040 : 16'h0200;
      chk($sformatf("wrap_pop_%0d", i), 32'(lrd_data_out), 32'(exp_d));
    end
    lrd_valid_in = 1'b0;
    chk("wrap_count0", 32'(lrd_count_out), 32'd0);

    // Underflow on empty, then clear with a pop pending
    lrd_valid_in = 1'b1;
    lrd_data_in  = 16'h0300;
    tick();
    chk("unf_data", 32'(lrd_data_out), 32'h0300);
    chk("unf_valid", 32'(lrd_valid_out), 32'h1);
    chk("unf_flag", 32'(lrd_underflow_out), 32'h1);
    chk("unf_count", 32'(lrd_count_out), 32'd0);
    lrd_clear_in = 1'b1;
    tick();
    idle_inputs();
    chk_all_zero("clear");

    // Same-cycle push and pop on empty
    lrd_h_valid_in = 1'b1;
    lrd_h_data_in  = 16'hFF00;
    lrd_valid_in   = 1'b1;
    lrd_data_in    = 16'h0200;
    tick();
    idle_inputs();
`ifdef LRD_BYPASS_EN
    chk("byp_data", 32'(lrd_data_out), 32'h0040);
    chk("byp_unf", 32'(lrd_underflow_out), 32'h0);
    chk("byp_count", 32'(lrd_count_out), 32'd0);
`else
    chk("nobyp_data", 32'(lrd_data_out), 32'h0200);
    chk("nobyp_unf", 32'(lrd_underflow_out), 32'h1);
    chk("nobyp_count", 32'(lrd_count_out), 32'd1);
    lrd_valid_in = 1'b1;
    lrd_data_in  = 16'h0200;
    tick();
    idle_inputs();
    chk("nobyp_stored", 32'(lrd_data_out), 32'h0040);
`endif
    lrd_clear_in = 1'b1; tick(); lrd_clear_in = 1'b0;

    // Asynchronous reset mid-stream
    lrd_h_valid_in = 1'b1;
    lrd_h_data_in = 16'h0100; tick();
    lrd_h_data_in = 16'hFF00; tick();
    lrd_h_valid_in = 1'b0;
    lrd_valid_in = 1'b1;
    lrd_data_in  = 16'h0200;
    tick();
    lrd_valid_in = 1'b0;
    chk("pre_rst_data", 32'(lrd_data_out), 32'h0200);
    chk("pre_rst_count", 32'(lrd_count_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #1;
    rst_n = 1'b1;
    lrd_valid_in = 1'b1;
    lrd_data_in  = 16'h0500;
    tick();
    idle_inputs();
    chk("post_rst_data", 32'(lrd_data_out), 32'h0500);
    chk("post_rst_unf", 32'(lrd_underflow_out), 32'h1);
    chk("post_rst_count", 32'(lrd_count_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
